serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It time-shares a single 1-bit full_adder cell to add two W-bit operands, one bit per clock cycle, LSB first.
- Operands are accepted on a valid/ready input handshake.
- The W-bit sum and the carry-out are presented on a valid/ready output handshake.
- It is used wherever area matters more than latency. It is the sequencing layer above the team's full_adder cell.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_ctrl_if.sv | 29 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W = 8;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl; master drives operands, slave computes.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int W = DEFAULT_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/full_adder.sv
// 1-bit full adder cell, time-shared by the serial adder controller.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one full_adder evaluation per clock, LSB first,
// operands in and sum/carry out over valid/ready handshakes.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  sum_sh_q, sum_sh_d;
    logic [W-1:0]  sum_shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          fa_sum, fa_cout;

    full_adder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB so the first computed bit lands in bit 0 after W shifts.
    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_sum_shift
            assign sum_shifted[gi] = sum_sh_q[gi+1];
        end
    endgenerate
    assign sum_shifted[W-1] = fa_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_shifted;
                carry_d  = fa_cout;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.sum       = (state_q == DONE) ? sum_sh_q : '0;
    assign bus.cout      = (state_q == DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at W=8, W=2 and W=1 against a+b+cin.
module tb_serial_add_ctrl;

    logic clk;
    logic rst;

    serial_add_ctrl_if #(.W(8)) bus8 ();
    serial_add_ctrl_if #(.W(2)) bus2 ();
    serial_add_ctrl_if #(.W(1)) bus1 ();

    serial_add_ctrl #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_add_ctrl #(.W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    serial_add_ctrl #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Index 0 = W8, 1 = W2, 2 = W1
    logic       in_valid_t  [3];
    logic       out_ready_t [3];
    logic       cin_t       [3];
    logic [7:0] a_t         [3];
    logic [7:0] b_t         [3];
    logic       ov          [3];
    logic       ir          [3];
    logic       bz          [3];
    logic       co          [3];
    logic [7:0] sm          [3];

    assign bus8.in_valid  = in_valid_t[0];
    assign bus8.out_ready = out_ready_t[0];
    assign bus8.cin       = cin_t[0];
    assign bus8.a         = a_t[0];
    assign bus8.b         = b_t[0];
    assign bus2.in_valid  = in_valid_t[1];
    assign bus2.out_ready = out_ready_t[1];
    assign bus2.cin       = cin_t[1];
    assign bus2.a         = a_t[1][1:0];
    assign bus2.b         = b_t[1][1:0];
    assign bus1.in_valid  = in_valid_t[2];
    assign bus1.out_ready = out_ready_t[2];
    assign bus1.cin       = cin_t[2];
    assign bus1.a         = a_t[2][0:0];
    assign bus1.b         = b_t[2][0:0];

    assign ov[0] = bus8.out_valid;
    assign ov[1] = bus2.out_valid;
    assign ov[2] = bus1.out_valid;
    assign ir[0] = bus8.in_ready;
    assign ir[1] = bus2.in_ready;
    assign ir[2] = bus1.in_ready;
    assign bz[0] = bus8.busy;
    assign bz[1] = bus2.busy;
    assign bz[2] = bus1.busy;
    assign co[0] = bus8.cout;
    assign co[1] = bus2.cout;
    assign co[2] = bus1.cout;
    assign sm[0] = bus8.sum;
    assign sm[1] = {6'd0, bus2.sum};
    assign sm[2] = {7'd0, bus1.sum};

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int wid(input int sel);
        case (sel)
            0:       return 8;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // One full transaction: handshake, latency count, result check, optional stall, release.
    task automatic txn(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input int stall, input bit pulse11);
        int         w;
        int         n;
        logic [8:0] tot;
        logic [7:0] mask;
        logic [7:0] es;
        logic       ec;
        w    = wid(sel);
        mask = 8'((1 << w) - 1);
        tot  = 9'(a & mask) + 9'(b & mask) + 9'(c);
        es   = tot[7:0] & mask;
        ec   = tot[w];
        check("in_ready_idle", 32'(ir[sel]), 32'd1);
        in_valid_t[sel]  = 1'b1;
        a_t[sel]         = a;
        b_t[sel]         = b;
        cin_t[sel]       = c;
        out_ready_t[sel] = (stall == 0);
        wait_cyc();
        in_valid_t[sel] = 1'b0;
        n = 1;
        while (!ov[sel] && n <= w + 5) begin
            check("busy_run", 32'(bz[sel]), 32'd1);
            check("masked_run", {23'd0, co[sel], sm[sel]}, 32'd0);
            in_valid_t[sel] = 1'($urandom);
            a_t[sel]        = 8'($urandom);
            b_t[sel]        = 8'($urandom);
            wait_cyc();
            n++;
        end
        check("latency", 32'(n), 32'(w + 1));
        check("sum", 32'(sm[sel]), 32'(es));
        check("cout", 32'(co[sel]), 32'(ec));
        check("in_ready_done", 32'(ir[sel]), 32'd0);
        for (int i = 0; i < stall; i++) begin
            if (pulse11) begin
                in_valid_t[sel] = (i == 0);
                a_t[sel]        = 8'h11;
            end else begin
                in_valid_t[sel] = 1'($urandom);
                a_t[sel]        = 8'($urandom);
            end
            wait_cyc();
            check("hold_valid", 32'(ov[sel]), 32'd1);
            check("hold_sum", 32'(sm[sel]), 32'(es));
            check("hold_cout", 32'(co[sel]), 32'(ec));
        end
        out_ready_t[sel] = 1'b1;
        wait_cyc();
        in_valid_t[sel] = 1'b0;
        check("release_valid", 32'(ov[sel]), 32'd0);
        check("release_in_ready", 32'(ir[sel]), 32'd1);
        $display("txn W=%0d a=%0h b=%0h cin=%0d stall=%0d -> sum=%0h cout=%0d", w, a & mask, b & mask, c, stall, es, ec);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_t[i]  = 1'b0;
            out_ready_t[i] = 1'b1;
            cin_t[i]       = 1'b0;
            a_t[i]         = 8'h00;
            b_t[i]         = 8'h00;
        end
        #1 rst = 1'b1;
        #2;
        for (int s = 0; s < 3; s++) begin
            check("rst_out_valid", 32'(ov[s]), 32'd0);
            check("rst_in_ready", 32'(ir[s]), 32'd1);
            check("rst_busy", 32'(bz[s]), 32'd0);
            check("rst_sum_cout", {23'd0, co[s], sm[s]}, 32'd0);
        end
        in_valid_t[0] = 1'b1;
        repeat (2) wait_cyc();
        check("rst_ignores_in_valid", 32'(bz[0]), 32'd0);
        in_valid_t[0] = 1'b0;
        rst = 1'b0;
        wait_cyc();

        txn(0, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        txn(0, 8'hFF, 8'h01, 1'b0, 0, 1'b0);
        txn(0, 8'hA5, 8'h5A, 1'b1, 0, 1'b0);
        txn(0, 8'h3C, 8'h0F, 1'b0, 5, 1'b1);

        // Abort in the third RUN cycle with no clock edge between reset and the check.
        in_valid_t[0] = 1'b1;
        a_t[0]        = 8'h12;
        b_t[0]        = 8'h34;
        cin_t[0]      = 1'b0;
        wait_cyc();
        in_valid_t[0] = 1'b0;
        repeat (2) wait_cyc();
        check("midop_busy", 32'(bz[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midop_rst_valid", 32'(ov[0]), 32'd0);
        check("midop_rst_in_ready", 32'(ir[0]), 32'd1);
        check("midop_rst_busy", 32'(bz[0]), 32'd0);
        check("midop_rst_sum_cout", {23'd0, co[0], sm[0]}, 32'd0);
        wait_cyc();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_cyc();
            check("midop_no_valid", 32'(ov[0]), 32'd0);
        end
        $display("txn W=8 a=12 b=34 aborted by reset");
        txn(0, 8'h7F, 8'h01, 1'b0, 0, 1'b0);

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    txn(1, 8'(a), 8'(b), 1'(c), int'($urandom_range(0, 3)), 1'b0);
                end
            end
        end

        txn(2, 8'h01, 8'h01, 1'b1, 0, 1'b0);
        txn(2, 8'h00, 8'h01, 1'b0, 2, 1'b0);

        for (int i = 0; i < 12; i++) begin
            txn(0, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
